draw_cursor_overlay: RTL and testbench

DRAW_CURSOR_OVERLAY -- requirements
Module: draw_cursor_overlay

---
 rtl/vga_if.sv | 12 +
 rtl/draw_cursor_overlay.sv | 99 +++++++++
 tb/tb_draw_cursor_overlay.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// vga_if: VGA timing/pixel bundle passed between drawing stages
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic [11:0] rgb;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  modport in (input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cursor_overlay.sv
// draw_cursor_overlay: overlays an arrow, crosshair or box cursor onto a VGA pixel stream
module draw_cursor_overlay #(
  parameter int CUR_SIZE = 16,
  parameter int BLINK_FRAMES = 30,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  input logic [11:0] xpos,
  input logic [11:0] ypos,
  input logic [1:0] mode,
  input logic [11:0] color,
  input logic blink_en,
  vga_if.in in,
  vga_if.out out
);
  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic [11:0] rgb;
    logic p;
    logic [11:0] c;
  } px_t;
  localparam logic [11:0] CS = 12'(CUR_SIZE);
  localparam logic [11:0] CE = 12'(CUR_SIZE - 1);
  localparam logic [7:0] BL = 8'(BLINK_FRAMES - 1);
  px_t st [LATENCY];
  px_t nx [LATENCY];
  px_t t;
  logic [11:0] x_s, y_s, c_s;
  logic [1:0] m_s;
  logic [7:0] fcnt;
  logic vis, vb_d, vb_rise, hit, in_x, in_y;
  logic [12:0] dx, dy;
  assign vb_rise = in.vblnk & ~vb_d;
  assign dx = {1'b0, st[0].hc} - {1'b0, x_s};
  assign dy = {1'b0, st[0].vc} - {1'b0, y_s};
  assign in_x = !dx[12] && dx[11:0] < CS;
  assign in_y = !dy[12] && dy[11:0] < CS;
  assign hit = vis && (m_s == 2'd1 ? in_x && in_y && dx[11:0] <= dy[11:0] :
                       m_s == 2'd2 ? st[0].hc == x_s || st[0].vc == y_s :
                       m_s == 2'd3 ? in_x && in_y && (dx[11:0] == 12'd0 || dy[11:0] == 12'd0 ||
                                                      dx[11:0] == CE || dy[11:0] == CE) :
                       1'b0);
  // Hit and colour join the pipe one stage in; the last stage applies them so out.rgb is registered
  always_comb begin
    nx[0] = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb, 1'b0, 12'd0};
    t = '0;
    for (int k = 1; k < LATENCY; k++) begin
      t = st[k-1];
      if (k == 1) begin
        t.p = hit;
        t.c = c_s;
      end
      if (k == LATENCY - 1) t.rgb = t.p && !t.hb && !t.vb ? t.c : t.rgb;
      nx[k] = t;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= '{default: '0};
    else st <= nx;
  // vb_d resets high so a reset released during vblank waits for the next real rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_s <= '0;
      y_s <= '0;
      c_s <= '0;
      m_s <= '0;
      fcnt <= '0;
      vis <= 1'b1;
      vb_d <= 1'b1;
    end else begin
      vb_d <= in.vblnk;
      if (vb_rise) begin
        x_s <= xpos;
        y_s <= ypos;
        m_s <= mode;
        c_s <= color;
      end
      if (!blink_en) begin
        fcnt <= '0;
        vis <= 1'b1;
      end else if (vb_rise) begin
        fcnt <= fcnt == BL ? 8'd0 : fcnt + 8'd1;
        vis <= fcnt == BL ? ~vis : vis;
      end
    end
  assign out.hcount = st[LATENCY-1].hc;
  assign out.vcount = st[LATENCY-1].vc;
  assign out.hsync = st[LATENCY-1].hs;
  assign out.vsync = st[LATENCY-1].vs;
  assign out.hblnk = st[LATENCY-1].hb;
  assign out.vblnk = st[LATENCY-1].vb;
  assign out.rgb = st[LATENCY-1].rgb;
endmodule

// File: tb/tb_draw_cursor_overlay.sv
// tb_draw_cursor_overlay: directed pixel vectors with a queued scoreboard checked by a monitor
module tb_draw_cursor_overlay;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [11:0] xpos = '0, ypos = '0, color = '0;
  logic [1:0] mode = '0;
  logic blink_en = 1'b0;
  int total = 0, bad = 0;
  typedef logic [42:0] pv_t;
  pv_t q [$];
  vga_if vin ();
  vga_if vout ();
  draw_cursor_overlay #(.CUR_SIZE(16), .BLINK_FRAMES(2), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .mode(mode), .color(color),
    .blink_en(blink_en), .in(vin), .out(vout)
  );
  always #5 clk = ~clk;
  function automatic pv_t outv();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction
  task automatic chk(input string name, input pv_t act, input pv_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h (hc,vc,hs,vs,hb,vb,rgb) t=%0t", name, act, e, $time);
    end
  endtask
  task automatic px(input logic [11:0] hc, input logic [11:0] vc, input logic hb, input logic vb,
                    input logic [11:0] rgb, input logic [11:0] e);
    logic hs, vs;
    hs = 1'($urandom);
    vs = 1'($urandom);
    vin.hcount = hc;
    vin.vcount = vc;
    vin.hsync = hs;
    vin.vsync = vs;
    vin.hblnk = hb;
    vin.vblnk = vb;
    vin.rgb = rgb;
    q.push_back({hc, vc, hs, vs, hb, vb, e});
    @(negedge clk);
  endtask
  task automatic frame();
    px(0, 0, 1, 0, 12'h123, 12'h123);
    px(0, 0, 1, 1, 12'h456, 12'h456);
  endtask
  task automatic setc(input logic [11:0] x, input logic [11:0] y, input logic [1:0] m, input logic [11:0] c);
    xpos = x;
    ypos = y;
    mode = m;
    color = c;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && q.size() >= L) chk("pix", outv(), q.pop_front());
  end
  initial begin
    vin.hcount = 12'hABC;
    vin.vcount = 12'h321;
    vin.hsync = 1'b1;
    vin.vsync = 1'b1;
    vin.hblnk = 1'b0;
    vin.vblnk = 1'b0;
    vin.rgb = 12'hFFF;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", outv(), '0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", outv(), '0);
    setc(100, 50, 1, 12'hF00);
    rst_n = 1'b1;
    px(100, 50, 0, 0, 12'h0AA, 12'h0AA);
    px(110, 60, 0, 0, 12'h0AB, 12'h0AB);
    setc(100, 50, 0, 12'hF00);
    for (int i = 0; i < 24; i++) begin
      logic [11:0] r;
      r = 12'($urandom);
      px(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), r, r);
    end
    setc(100, 50, 1, 12'hF00);
    frame();
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    px(100, 65, 0, 0, 12'h0AA, 12'hF00);
    px(115, 65, 0, 0, 12'h0AA, 12'hF00);
    px(101, 50, 0, 0, 12'h0AA, 12'h0AA);
    px(116, 65, 0, 0, 12'h0AA, 12'h0AA);
    px(99, 50, 0, 0, 12'h0AA, 12'h0AA);
    px(100, 50, 1, 0, 12'h0AA, 12'h0AA);
    xpos = 200;
    px(100, 300, 0, 0, 12'h0AA, 12'h0AA);
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    px(200, 50, 0, 0, 12'h0AA, 12'h0AA);
    frame();
    px(200, 50, 0, 0, 12'h0AA, 12'hF00);
    px(100, 50, 0, 0, 12'h0AA, 12'h0AA);
    setc(320, 240, 2, 12'h0F0);
    px(320, 240, 0, 0, 12'h0AA, 12'h0AA);
    frame();
    px(320, 10, 0, 0, 12'h0AA, 12'h0F0);
    px(5, 240, 0, 0, 12'h0AA, 12'h0F0);
    px(321, 241, 0, 0, 12'h0AA, 12'h0AA);
    px(320, 500, 1, 0, 12'h0AA, 12'h0AA);
    px(700, 240, 0, 1, 12'h0AA, 12'h0AA);
    px(320, 241, 0, 0, 12'h0AA, 12'h0F0);
    setc(100, 50, 1, 12'hF00);
    frame();
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    blink_en = 1'b1;
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    for (int f = 1; f < 6; f++) begin
      frame();
      px(100, 50, 0, 0, 12'h0AA, (f == 2 || f == 3) ? 12'h0AA : 12'hF00);
    end
    blink_en = 1'b0;
    frame();
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    frame();
    px(100, 50, 0, 0, 12'h0AA, 12'hF00);
    setc(4090, 10, 3, 12'h00F);
    frame();
    px(4090, 10, 0, 0, 12'h0AA, 12'h00F);
    px(4095, 10, 0, 0, 12'h0AA, 12'h00F);
    px(4095, 12, 0, 0, 12'h0AA, 12'h0AA);
    px(4090, 20, 0, 0, 12'h0AA, 12'h00F);
    px(0, 10, 0, 0, 12'h0AA, 12'h0AA);
    px(9, 10, 0, 0, 12'h0AA, 12'h0AA);
    px(5, 25, 0, 0, 12'h0AA, 12'h0AA);
    px(4091, 10, 0, 0, 12'h0AA, 12'h00F);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", outv(), '0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    px(4090, 10, 0, 0, 12'h0AA, 12'h0AA);
    px(4095, 10, 0, 0, 12'h0AA, 12'h0AA);
    frame();
    px(4090, 10, 0, 0, 12'h0AA, 12'h00F);
    repeat (L + 1) px(0, 0, 1, 1, 12'h000, 12'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
